// File: rtl/sd_cmd_engine_pkg.sv
// Shared types, frame constants and the CRC7 step used by the SD command engine.
package sd_pkg;

    typedef enum logic [1:0] {
        RSP_NONE = 2'd0,
        RSP_R48  = 2'd1,
        RSP_R3   = 2'd2,
        RSP_R136 = 2'd3
    } rsp_type_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_TX,
        S_WAIT,
        S_RX,
        S_TRAIL,
        S_DONE
    } state_e;

    localparam int unsigned STAT_TIMEOUT = 0;
    localparam int unsigned STAT_CRC     = 1;
    localparam int unsigned STAT_END     = 2;

    localparam int unsigned FRAME_R48  = 48;
    localparam int unsigned FRAME_R136 = 136;

    // One serial step of CRC7, polynomial x^7 + x^3 + 1.
    function automatic logic [6:0] crc7_next(input logic [6:0] crc, input logic din);
        logic fb;
        fb = din ^ crc[6];
        return {crc[5:3], crc[2] ^ fb, crc[1:0], fb};
    endfunction

endpackage

// File: rtl/sd_cmd_engine_crc7.sv
// Serial CRC7 accumulator; clear has priority over enable.
module crc7
    import sd_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       en,
    input  logic       din,
    output logic [6:0] crc
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            crc <= '0;
        end else if (clr) begin
            crc <= '0;
        end else if (en) begin
            crc <= crc7_next(crc, din);
        end
    end

endmodule

// File: rtl/sd_cmd_engine.sv
// SD CMD-line engine: sends one command frame with CRC7, optionally receives and
// checks an R48/R136 response, and drives a gated, divided sd_clk.
module sd_cmd_engine
    import sd_pkg::*;
#(
    parameter int unsigned DIVW    = 8,
    parameter int unsigned NCR_MAX = 64,
    parameter int unsigned NCC     = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [DIVW-1:0] clk_div,
    input  logic            cmd_valid,
    output logic            cmd_ready,
    input  logic [5:0]      cmd_index,
    input  logic [31:0]     cmd_arg,
    input  logic [1:0]      rsp_type,
    input  logic            abort,
    output logic            rsp_valid,
    output logic [2:0]      rsp_status,
    output logic [5:0]      rsp_index,
    output logic [127:0]    rsp_data,
    output logic            sd_clk,
    output logic            sd_cmd_out,
    output logic            sd_cmd_oe,
    input  logic            sd_cmd_in
);

    localparam int unsigned NW = $clog2(NCR_MAX + 1);
    localparam int unsigned TW = $clog2(NCC + 1);

    localparam logic [7:0] RX_LAST_48   = 8'(FRAME_R48 - 2);
    localparam logic [7:0] RX_LAST_136  = 8'(FRAME_R136 - 2);
    localparam logic [7:0] FEED_END_48  = 8'(FRAME_R48 - 10);
    localparam logic [7:0] FEED_BEG_136 = 8'(FRAME_R136 - 129);
    localparam logic [7:0] FEED_END_136 = 8'(FRAME_R136 - 10);

    state_e          state, state_nxt;
    rsp_type_e       rtype_q;
    logic [DIVW-1:0] div_q, div_cnt;
    logic            sd_clk_q;
    logic [47:0]     tx_sr;
    logic [5:0]      bit_idx;
    logic [NW-1:0]   ncr_cnt;
    logic [TW-1:0]   trail_cnt;
    logic [7:0]      rx_cnt;
    logic [126:0]    rx_sr;
    logic [127:0]    rx_frame;
    logic [2:0]      st_status;
    logic [5:0]      st_index;
    logic [127:0]    st_data;
    logic [6:0]      crc_q;

    logic busy, tick, rise, fall, accept, abort_hit;
    logic rx_last_bit, rx_feed, crc_clr, crc_en, crc_din;

    assign busy      = (state == S_TX) || (state == S_WAIT) || (state == S_RX) || (state == S_TRAIL);
    assign tick      = busy && (div_cnt == '0);
    assign rise      = tick && !sd_clk_q;
    assign fall      = tick && sd_clk_q;
    assign accept    = cmd_valid && cmd_ready;
    assign abort_hit = abort && busy;
    assign rx_frame  = {rx_sr, sd_cmd_in};

    assign rx_last_bit = (rtype_q == RSP_R136) ? (rx_cnt == RX_LAST_136) : (rx_cnt == RX_LAST_48);
    // R136 CRC skips the start/transmit/reserved prefix, so feeding starts late
    assign rx_feed = (rtype_q == RSP_R136) ? ((rx_cnt >= FEED_BEG_136) && (rx_cnt <= FEED_END_136))
                                           : (rx_cnt <= FEED_END_48);

    assign crc_clr = accept || ((state == S_WAIT) && rise && !sd_cmd_in);
    assign crc_en  = ((state == S_TX) && rise && (bit_idx < 6'd40)) ||
                     ((state == S_RX) && rise && rx_feed);
    assign crc_din = (state == S_TX) ? tx_sr[47] : sd_cmd_in;

    crc7 u_crc7 (
        .clk (clk),
        .rst (rst),
        .clr (crc_clr),
        .en  (crc_en),
        .din (crc_din),
        .crc (crc_q)
    );

    always_comb begin
        state_nxt  = state;
        cmd_ready  = 1'b0;
        rsp_valid  = 1'b0;
        sd_cmd_oe  = 1'b0;
        sd_cmd_out = 1'b1;
        sd_clk     = sd_clk_q;
        unique case (state)
            S_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) state_nxt = S_TX;
            end
            S_TX: begin
                sd_cmd_oe  = 1'b1;
                sd_cmd_out = tx_sr[47];
                if (rise && (bit_idx == 6'd47))
                    state_nxt = (rtype_q == RSP_NONE) ? S_TRAIL : S_WAIT;
            end
            S_WAIT: begin
                if (rise) begin
                    if (!sd_cmd_in)
                        state_nxt = S_RX;
                    else if (ncr_cnt == NW'(NCR_MAX - 1))
                        state_nxt = S_TRAIL;
                end
            end
            S_RX: begin
                if (rise && rx_last_bit) state_nxt = S_TRAIL;
            end
            S_TRAIL: begin
                sd_cmd_oe = 1'b1;
                if (fall && (trail_cnt == TW'(NCC))) state_nxt = S_DONE;
            end
            S_DONE: begin
                cmd_ready = 1'b1;
                rsp_valid = 1'b1;
                state_nxt = cmd_valid ? S_TX : S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
        if (abort_hit) state_nxt = S_IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            rtype_q    <= RSP_NONE;
            div_q      <= '0;
            div_cnt    <= '0;
            sd_clk_q   <= 1'b0;
            tx_sr      <= '0;
            bit_idx    <= '0;
            ncr_cnt    <= '0;
            trail_cnt  <= '0;
            rx_cnt     <= '0;
            rx_sr      <= '0;
            st_status  <= '0;
            st_index   <= '0;
            st_data    <= '0;
            rsp_status <= '0;
            rsp_index  <= '0;
            rsp_data   <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                rtype_q   <= rsp_type_e'(rsp_type);
                div_q     <= clk_div;
                div_cnt   <= clk_div;
                sd_clk_q  <= 1'b0;
                tx_sr     <= {2'b01, cmd_index, cmd_arg, 8'h00};
                bit_idx   <= '0;
                ncr_cnt   <= '0;
                trail_cnt <= '0;
                rx_cnt    <= '0;
                st_status <= '0;
                st_index  <= '0;
                st_data   <= '0;
            end else if (abort_hit) begin
                sd_clk_q <= 1'b0;
            end else if (busy) begin
                if (tick) begin
                    div_cnt  <= div_q;
                    sd_clk_q <= ~sd_clk_q;
                end else begin
                    div_cnt <= div_cnt - DIVW'(1);
                end
                unique case (state)
                    S_TX: begin
                        if (fall) begin
                            bit_idx <= bit_idx + 6'd1;
                            // CRC is final after the 40th rise; splice it in with the end bit
                            if (bit_idx == 6'd39)
                                tx_sr <= {crc_q, 1'b1, 40'h0};
                            else
                                tx_sr <= {tx_sr[46:0], 1'b0};
                        end
                    end
                    S_WAIT: begin
                        if (rise) begin
                            ncr_cnt <= ncr_cnt + NW'(1);
                            if (sd_cmd_in && (ncr_cnt == NW'(NCR_MAX - 1)))
                                st_status[STAT_TIMEOUT] <= 1'b1;
                        end
                    end
                    S_RX: begin
                        if (rise) begin
                            rx_sr  <= rx_frame[126:0];
                            rx_cnt <= rx_cnt + 8'd1;
                            if (rx_last_bit) begin
                                st_status[STAT_END] <= !sd_cmd_in;
                                st_status[STAT_CRC] <= (rtype_q != RSP_R3) && (crc_q != rx_frame[7:1]);
                                if (rtype_q == RSP_R136) begin
                                    st_data <= rx_frame;
                                end else begin
                                    st_index <= rx_frame[45:40];
                                    st_data  <= {96'h0, rx_frame[39:8]};
                                end
                            end
                        end
                    end
                    S_TRAIL: begin
                        if (rise) trail_cnt <= trail_cnt + TW'(1);
                    end
                    default: ;
                endcase
            end
            if ((state == S_TRAIL) && (state_nxt == S_DONE)) begin
                rsp_status <= st_status;
                rsp_index  <= st_index;
                rsp_data   <= st_data;
            end
        end
    end

endmodule

// File: tb/tb_sd_cmd_engine.sv
// Directed bench for sd_cmd_engine: vector table with a card model, plus abort/reset sequences.
module tb_sd_cmd_engine;

    localparam int NCR = 64;
    localparam int NCC = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic [7:0]   clk_div;
    logic         cmd_valid;
    logic         cmd_ready;
    logic [5:0]   cmd_index;
    logic [31:0]  cmd_arg;
    logic [1:0]   rsp_type;
    logic         abort;
    logic         rsp_valid;
    logic [2:0]   rsp_status;
    logic [5:0]   rsp_index;
    logic [127:0] rsp_data;
    logic         sd_clk;
    logic         sd_cmd_out;
    logic         sd_cmd_oe;
    logic         sd_cmd_in;

    sd_cmd_engine #(.DIVW(8), .NCR_MAX(NCR), .NCC(NCC)) dut (
        .clk        (clk),
        .rst        (rst),
        .clk_div    (clk_div),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_index  (cmd_index),
        .cmd_arg    (cmd_arg),
        .rsp_type   (rsp_type),
        .abort      (abort),
        .rsp_valid  (rsp_valid),
        .rsp_status (rsp_status),
        .rsp_index  (rsp_index),
        .rsp_data   (rsp_data),
        .sd_clk     (sd_clk),
        .sd_cmd_out (sd_cmd_out),
        .sd_cmd_oe  (sd_cmd_oe),
        .sd_cmd_in  (sd_cmd_in)
    );

    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;

    task automatic check(input string name, input logic [135:0] act, input logic [135:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Reference CRC7 by polynomial division over the low n bits of data, MSB first.
    function automatic logic [6:0] ref_crc7(input logic [135:0] data, input int n);
        logic [6:0] r;
        logic       fb;
        r = '0;
        for (int i = n - 1; i >= 0; i--) begin
            fb = data[i] ^ r[6];
            r  = {r[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
        end
        return r;
    endfunction

    function automatic logic [47:0] mk_cmd(input logic [5:0] idx, input logic [31:0] arg);
        logic [39:0] p;
        p = {2'b01, idx, arg};
        return {p, ref_crc7({96'h0, p}, 40), 1'b1};
    endfunction

    typedef struct {
        logic [5:0]   idx;
        logic [31:0]  arg;
        logic [1:0]   rtype;
        logic [7:0]   div;
        logic [135:0] reply;
        int           rlen;
        int           delay;
        logic [47:0]  exp_tx;
        logic [2:0]   exp_status;
        logic [5:0]   exp_index;
        logic [127:0] exp_data;
        int           exp_done;
        int           exp_to;
    } vec_t;

    // Issue one command and play the card; n_done counts clk cycles from accept to rsp_valid,
    // n_end counts from the end-bit rise to rsp_valid.
    task automatic run_cmd(input vec_t v, input int abort_k, input int limit,
                           output logic [47:0] txf, output bit got,
                           output int n_done, output int n_end);
        int txbits, rises_after, k, n, end_n;
        bit pclk, pout, poe, aborted;
        txf = '0; got = 1'b0; n_done = 0; n_end = 0;
        txbits = 0; rises_after = 0; k = 0; end_n = 0; aborted = 1'b0;
        @(negedge clk);
        cmd_index = v.idx; cmd_arg = v.arg; rsp_type = v.rtype; clk_div = v.div;
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        clk_div   = ~v.div;
        n = 1;
        pclk = sd_clk; pout = sd_cmd_out; poe = sd_cmd_oe;
        while (n < limit) begin
            if (rsp_valid) begin
                got = 1'b1; n_done = n; n_end = n - end_n;
                break;
            end
            if (sd_clk && !pclk) begin
                if (txbits < 48 && poe) begin
                    txf = {txf[46:0], pout};
                    txbits++;
                    if (txbits == 48) end_n = n;
                end else if (txbits == 48) begin
                    rises_after++;
                end
            end
            if (!sd_clk && pclk && txbits == 48 && v.rlen > 0 && rises_after >= v.delay) begin
                if (k < v.rlen) begin
                    sd_cmd_in = v.reply[v.rlen - 1 - k];
                    k++;
                end else begin
                    sd_cmd_in = 1'b1;
                end
            end
            pclk = sd_clk; pout = sd_cmd_out; poe = sd_cmd_oe;
            if (abort_k > 0 && k == abort_k && !aborted) begin
                aborted = 1'b1;
                abort = 1'b1;
                @(negedge clk);
                abort = 1'b0;
                n++;
                check("abort rx sd_clk", sd_clk, 0);
                check("abort rx oe", sd_cmd_oe, 0);
                check("abort rx ready", cmd_ready, 1);
                pclk = sd_clk; pout = sd_cmd_out; poe = sd_cmd_oe;
            end
            @(negedge clk);
            n++;
        end
        sd_cmd_in = 1'b1;
    endtask

    vec_t         vecs[9];
    vec_t         va;
    logic [119:0] cid_body;
    logic [127:0] cid;
    logic [47:0]  txf;
    bit           got, seen;
    int           nd, ne, n;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; clk_div = '0; cmd_valid = 1'b0; cmd_index = '0; cmd_arg = '0;
        rsp_type = '0; abort = 1'b0; sd_cmd_in = 1'b1;

        cid_body = 120'h0353445344333280123456780114B5;
        cid = {cid_body, ref_crc7({16'h0, cid_body}, 120), 1'b1};

        //          idx    arg            rt    div    reply                         rlen dly exp_tx                    st      idx    data                 done        to
        vecs[0] = '{6'd0,  32'h0,        2'd0, 8'd0, 136'h0,                      0,   2, 48'h400000000095,         3'b000, 6'd0,  128'h0,              113,        0};
        vecs[1] = '{6'd8,  32'h1AA,      2'd1, 8'd1, 136'h08000001AA13,           48,  2, 48'h48000001AA87,         3'b000, 6'd8,  128'h1AA,            0,          0};
        vecs[2] = '{6'd8,  32'h1AA,      2'd1, 8'd1, 136'h08000001AA11,           48,  2, 48'h48000001AA87,         3'b010, 6'd8,  128'h1AA,            0,          0};
        vecs[3] = '{6'd8,  32'h1AA,      2'd1, 8'd0, 136'h08000001AA12,           48,  5, 48'h48000001AA87,         3'b100, 6'd8,  128'h1AA,            0,          0};
        vecs[4] = '{6'd55, 32'h0,        2'd1, 8'd0, 136'h0,                      0,   2, 48'h770000000065,         3'b001, 6'd0,  128'h0,              0,          145};
        vecs[5] = '{6'd0,  32'h0,        2'd0, 8'd3, 136'h0,                      0,   2, 48'h400000000095,         3'b000, 6'd0,  128'h0,              112*4+1,    0};
        vecs[6] = '{6'd41, 32'h40FF8000, 2'd2, 8'd0, 136'h3F80FF8000FF,           48,  2, mk_cmd(6'd41, 32'h40FF8000), 3'b000, 6'h3F, 128'h80FF8000,    0,          0};
        vecs[7] = '{6'd2,  32'h0,        2'd3, 8'd0, {8'h3F, cid},                136, 3, mk_cmd(6'd2, 32'h0),      3'b000, 6'd0,  cid,                 0,          0};
        vecs[8] = '{6'd2,  32'h0,        2'd3, 8'd1, {8'h3F, cid ^ 128'h2},       136, 3, mk_cmd(6'd2, 32'h0),      3'b010, 6'd0,  cid ^ 128'h2,        0,          0};

        repeat (3) @(negedge clk);
        check("reset sd_clk", sd_clk, 0);
        check("reset cmd_out", sd_cmd_out, 1);
        check("reset oe", sd_cmd_oe, 0);
        check("reset ready", cmd_ready, 1);
        check("reset valid", rsp_valid, 0);
        check("reset status", rsp_status, 0);
        check("reset index", rsp_index, 0);
        check("reset data", rsp_data, 0);
        rst = 1'b0;

        for (int i = 0; i < 9; i++) begin
            run_cmd(vecs[i], 0, 5000, txf, got, nd, ne);
            check($sformatf("v%0d rsp_valid", i), got, 1);
            check($sformatf("v%0d tx frame", i), txf, vecs[i].exp_tx);
            check($sformatf("v%0d status", i), rsp_status, vecs[i].exp_status);
            check($sformatf("v%0d index", i), rsp_index, vecs[i].exp_index);
            check($sformatf("v%0d data", i), rsp_data, vecs[i].exp_data);
            check($sformatf("v%0d ready", i), cmd_ready, 1);
            if (vecs[i].exp_done != 0)
                check($sformatf("v%0d done cycles", i), nd, vecs[i].exp_done);
            if (vecs[i].exp_to != 0)
                check($sformatf("v%0d timeout cycles", i), ne, vecs[i].exp_to * (int'(vecs[i].div) + 1));
            @(negedge clk);
            check($sformatf("v%0d valid one cycle", i), rsp_valid, 0);
        end

        // Abort together with cmd_valid in IDLE still accepts; clk_div 249 gives 500-clk periods.
        @(negedge clk);
        cmd_index = 6'd0; cmd_arg = '0; rsp_type = 2'd0; clk_div = 8'd249;
        cmd_valid = 1'b1; abort = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0; abort = 1'b0;
        check("abort+valid accepted", cmd_ready, 0);
        n = 1;
        while (!sd_clk && n < 1000) begin @(negedge clk); n++; end
        check("div249 first rise", n, 251);
        n = 0;
        while (sd_clk && n < 1000) begin @(negedge clk); n++; end
        check("div249 high phase", n, 250);
        n = 0;
        while (!sd_clk && n < 1000) begin @(negedge clk); n++; end
        check("div249 low phase", n, 250);
        repeat (3) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort tx sd_clk", sd_clk, 0);
        check("abort tx oe", sd_cmd_oe, 0);
        check("abort tx cmd_out", sd_cmd_out, 1);
        check("abort tx ready", cmd_ready, 1);
        seen = 1'b0;
        repeat (100) begin @(negedge clk); if (rsp_valid) seen = 1'b1; end
        check("abort tx no rsp_valid", seen, 0);

        // Abort in the middle of a response.
        va = vecs[1];
        va.div = 8'd0;
        run_cmd(va, 10, 600, txf, got, nd, ne);
        check("abort rx no rsp_valid", got, 0);

        // Engine recovers normally afterwards.
        run_cmd(vecs[1], 0, 5000, txf, got, nd, ne);
        check("recover rsp_valid", got, 1);
        check("recover status", rsp_status, 0);
        check("recover data", rsp_data, 128'h1AA);

        // Asynchronous reset in the middle of TX.
        @(negedge clk);
        cmd_index = 6'd8; cmd_arg = 32'h1AA; rsp_type = 2'd1; clk_div = 8'd0; cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (30) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("rst sd_clk", sd_clk, 0);
        check("rst cmd_out", sd_cmd_out, 1);
        check("rst oe", sd_cmd_oe, 0);
        check("rst ready", cmd_ready, 1);
        check("rst valid", rsp_valid, 0);
        check("rst status", rsp_status, 0);
        check("rst data", rsp_data, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst ready after", cmd_ready, 1);
        seen = 1'b0;
        repeat (200) begin @(negedge clk); if (rsp_valid) seen = 1'b1; end
        check("rst no rsp_valid", seen, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
